// File: rtl/ifmap_row_streamer_pkg.sv
// Shared definitions for the tagged IFMap stream: default widths, row-tag bit
// positions (also used by the loader) and the streamer FSM encoding.
package ifmap_row_streamer_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_MEM_ADDR_WIDTH = 10;
  localparam int DEF_LEN_WIDTH      = 8;

  localparam int SOR_BIT    = DEF_DATA_WIDTH + 1;
  localparam int EOR_BIT    = DEF_DATA_WIDTH;
  localparam int WORD_WIDTH = DEF_DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } stream_state_e;

endpackage

// File: rtl/ifmap_row_streamer_if.sv
// Bus bundle between the row streamer and its environment: transfer control,
// source-memory read port and the tagged output stream.
interface ifmap_row_streamer_if
  import ifmap_row_streamer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
);

  logic                      start;
  logic [MEM_ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]      row_len;
  logic [LEN_WIDTH-1:0]      num_rows;
  logic                      mem_ren;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      buff_ready;
  logic                      out_wen;
  logic [DATA_WIDTH+1:0]     out_data;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, base_addr, row_len, num_rows, mem_rdata, buff_ready,
    output mem_ren, mem_addr, out_wen, out_data, busy, done
  );

  modport slave (
    output start, base_addr, row_len, num_rows, mem_rdata, buff_ready,
    input  mem_ren, mem_addr, out_wen, out_data, busy, done
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO for stream producers. Head is always in slot 0 so
// dout is a plain register and holds while nothing is popped.
module stream_skid_buf #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] q0_r;
  logic [WIDTH-1:0] q1_r;
  logic [1:0]       count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (count_r != 2'd0);
  assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

  // Storage shift/fill and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_r    <= '0;
      q1_r    <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b11: begin
          if (count_r == 2'd2) begin
            q0_r <= q1_r;
            q1_r <= din;
          end else begin
            q0_r <= din;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            q0_r <= din;
          end else begin
            q1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          q0_r    <= q1_r;
          count_r <= count_r - 2'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout  = q0_r;
  assign empty = (count_r == 2'd0);
  assign count = count_r;

endmodule

// File: rtl/ifmap_row_streamer.sv
// Reads a row-major IFMap region from synchronous-read memory and streams it
// as {start_of_row, end_of_row, element} words under a ready/wen handshake.
module ifmap_row_streamer
  import ifmap_row_streamer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  ifmap_row_streamer_if.master bus
);

  localparam logic [LEN_WIDTH-1:0]      LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

  stream_state_e             state_r;
  stream_state_e             state_s;
  logic [LEN_WIDTH-1:0]      len_r;
  logic [LEN_WIDTH-1:0]      rows_r;
  logic [LEN_WIDTH-1:0]      col_r;
  logic [LEN_WIDTH-1:0]      row_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic                      infl_vld_r;
  logic                      infl_sor_r;
  logic                      infl_eor_r;
  logic                      ren_s;
  logic                      pop_s;
  logic                      empty_s;
  logic [1:0]                count_s;
  logic [2:0]                occ_s;
  logic                      room_s;
  logic                      last_col_s;
  logic                      last_row_s;
  logic                      drained_s;
  logic [DATA_WIDTH+1:0]     din_s;
  logic [DATA_WIDTH+1:0]     head_s;

  assign last_col_s = (col_r == (len_r - LEN_ONE));
  assign last_row_s = (row_r == (rows_r - LEN_ONE));
  assign pop_s      = !empty_s && bus.buff_ready;

  // Credit: words held plus the read in flight, less this cycle's pop, must leave a free slot.
  assign occ_s  = {1'b0, count_s} + {2'b00, infl_vld_r} - {2'b00, pop_s};
  assign room_s = (occ_s < 3'd2);

  // Drained once nothing is in flight and the buffer empties by the end of this cycle.
  assign drained_s = !infl_vld_r &&
                     ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s));

  // Next-state and read-issue decision.
  always_comb begin
    state_s = state_r;
    ren_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if ((len_r != '0) && (rows_r != '0)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_RUN: begin
        if (room_s) begin
          ren_s = 1'b1;
          if (last_col_s && last_row_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Parameter latch plus col/row and running address counters; the address wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r  <= '0;
      rows_r <= '0;
      col_r  <= '0;
      row_r  <= '0;
      addr_r <= '0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      len_r  <= bus.row_len;
      rows_r <= bus.num_rows;
      col_r  <= '0;
      row_r  <= '0;
      addr_r <= bus.base_addr;
    end else if (ren_s) begin
      addr_r <= addr_r + ADDR_ONE;
      if (last_col_s) begin
        col_r <= '0;
        row_r <= row_r + LEN_ONE;
      end else begin
        col_r <= col_r + LEN_ONE;
      end
    end
  end

  // Row tags ride alongside the outstanding read until its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_vld_r <= 1'b0;
      infl_sor_r <= 1'b0;
      infl_eor_r <= 1'b0;
    end else begin
      infl_vld_r <= ren_s;
      infl_sor_r <= (col_r == '0);
      infl_eor_r <= last_col_s;
    end
  end

  assign din_s = {infl_sor_r, infl_eor_r, bus.mem_rdata};

  stream_skid_buf #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_vld_r),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (head_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign bus.mem_ren  = ren_s;
  assign bus.mem_addr = addr_r;
  assign bus.out_wen  = pop_s;
  assign bus.out_data = head_s;
  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.done     = (state_r == ST_DONE);

endmodule

// File: tb/tb_ifmap_row_streamer.sv
// Randomised scoreboard bench for ifmap_row_streamer: expected read addresses
// and tagged words are derived from row/column arithmetic over a memory image.
module tb_ifmap_row_streamer;
  import ifmap_row_streamer_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_MEM_ADDR_WIDTH;
  localparam int LW = DEF_LEN_WIDTH;

  logic clk = 1'b0;
  logic rst;

  ifmap_row_streamer_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ifmap_row_streamer #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_ren = 0;
  int n_wen = 0;
  int ren0 = 0;
  int wen0 = 0;
  int start_cyc = 0;
  int last_wen_cyc = 0;
  int xfer_words = 0;
  int ready_mode = 0;
  bit consec_chk = 1'b0;
  logic [DW+1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW+1:0] ew;
  logic [AW-1:0] ea;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // buff_ready: mode 0 always ready, mode 1 ready about two cycles in three
  initial begin
    bus.buff_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.buff_ready = 1'b1;
      else bus.buff_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // monitor: pops expected reads and words whenever the DUT presents them
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.mem_ren === 1'b1) begin
          n_ren++;
          checks++;
          if (addr_q.size() == 0) begin
            failures++;
            $display("FAIL rd_addr: unexpected read at %h", bus.mem_addr);
          end else begin
            ea = addr_q.pop_front();
            if (bus.mem_addr !== ea) begin
              failures++;
              $display("FAIL rd_addr: got %h expected %h", bus.mem_addr, ea);
            end
          end
        end
        if (bus.out_wen === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL word: unexpected word %h", bus.out_data);
          end else begin
            ew = exp_q.pop_front();
            if (bus.out_data !== ew) begin
              failures++;
              $display("FAIL word: got sor=%b eor=%b d=%h expected sor=%b eor=%b d=%h",
                       bus.out_data[SOR_BIT], bus.out_data[EOR_BIT], bus.out_data[DW-1:0],
                       ew[SOR_BIT], ew[EOR_BIT], ew[DW-1:0]);
            end
          end
          if (consec_chk && xfer_words > 0) begin
            checks++;
            if (cyc - last_wen_cyc != 1) begin
              failures++;
              $display("FAIL throughput: gap=%0d cycles expected 1", cyc - last_wen_cyc);
            end
          end
          xfer_words++;
          n_wen++;
          last_wen_cyc = cyc;
        end
      end
    end
  end

  task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [LW-1:0] n);
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    for (int r = 0; r < int'(n); r++) begin
      for (int c = 0; c < int'(l); c++) begin
        a = AW'(int'(b) + r * int'(l) + c);
        addr_q.push_back(a);
        exp_q.push_back({(c == 0), (c == int'(l) - 1), mem[a]});
      end
    end
    bus.base_addr = b;
    bus.row_len   = l;
    bus.num_rows  = n;
    bus.start     = 1'b1;
    start_cyc     = cyc;
    xfer_words    = 0;
    ren0          = n_ren;
    wen0          = n_wen;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_xfer(input bit zero);
    bit seen;
    int done_cyc;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: done=0 after 3000 cycles expected 1");
    end else begin
      done_cyc = cyc;
      checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
        failures++;
        $display("FAIL drained: words_left=%0d reads_left=%0d expected 0", exp_q.size(), addr_q.size());
      end
      checks++;
      if (zero) begin
        if (done_cyc - start_cyc != 2 || n_ren != ren0 || n_wen != wen0) begin
          failures++;
          $display("FAIL zero_xfer: done_after=%0d reads=%0d writes=%0d expected 2/0/0",
                   done_cyc - start_cyc, n_ren - ren0, n_wen - wen0);
        end
      end else if (done_cyc - last_wen_cyc != 1) begin
        failures++;
        $display("FAIL done_latency: %0d cycles after last word expected 1", done_cyc - last_wen_cyc);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL post_done: busy=%b done=%b expected 0/0", bus.busy, bus.done);
      end
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    bit seen;
    logic [AW-1:0] rb;
    logic [LW-1:0] rl;
    logic [LW-1:0] rn;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_len   = '0;
    bus.num_rows  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_ren !== 1'b0 || bus.mem_addr !== '0 || bus.out_wen !== 1'b0 ||
        bus.out_data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset: ren=%b addr=%h wen=%b data=%h busy=%b done=%b expected all 0",
               bus.mem_ren, bus.mem_addr, bus.out_wen, bus.out_data, bus.busy, bus.done);
    end
    rst = 1'b0;

    // basic 3x2 transfer, back-to-back words
    ready_mode = 0; consec_chk = 1'b1;
    start_xfer(10'h010, 8'd3, 8'd2);
    finish_xfer(1'b0);

    // same transfer under random backpressure
    ready_mode = 1; consec_chk = 1'b0;
    start_xfer(10'h010, 8'd3, 8'd2);
    finish_xfer(1'b0);

    // single-element rows carry both tags
    ready_mode = 0; consec_chk = 1'b1;
    start_xfer(10'h155, 8'd1, 8'd3);
    finish_xfer(1'b0);

    // empty transfers
    start_xfer(10'h020, 8'd0, 8'd5);
    finish_xfer(1'b1);
    start_xfer(10'h020, 8'd4, 8'd0);
    finish_xfer(1'b1);

    // address wrap
    start_xfer(10'h3FE, 8'd4, 8'd1);
    finish_xfer(1'b0);

    // second start and changed parameters mid-transfer are ignored
    start_xfer(10'h100, 8'd4, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 10'h200; bus.row_len = 8'd2; bus.num_rows = 8'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_xfer(1'b0);

    // reset after word 2, then replay from word 0
    start_xfer(10'h010, 8'd3, 8'd2);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (xfer_words >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL pre_reset_words: saw %0d words expected 3", xfer_words);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_wen !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_ren !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: wen=%b busy=%b done=%b ren=%b expected 0",
               bus.out_wen, bus.busy, bus.done, bus.mem_ren);
    end
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_xfer(10'h010, 8'd3, 8'd2);
    finish_xfer(1'b0);

    // random transfers
    for (int t = 0; t < 12; t++) begin
      rb = AW'($urandom);
      rl = LW'($urandom_range(1, 6));
      rn = LW'($urandom_range(1, 4));
      ready_mode = (t % 2);
      consec_chk = (ready_mode == 0);
      start_xfer(rb, rl, rn);
      finish_xfer(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
